// File: rtl/missile_pool_ctl.sv
// Missile pool controller: round-robin slot allocation, per-frame movement and retirement of player missiles.
// Optional macro AUTOFIRE_EN: holding fire re-arms a shot on every frame tick (rate limited by COOLDOWN).
module missile_pool_ctl #(
    parameter int unsigned SLOTS    = 4,
    parameter int unsigned Y_START  = 680,
    parameter int unsigned Y_MIN    = 0,
    parameter int unsigned SPEED    = 4,
    parameter int unsigned X_OFFSET = 30,
    parameter int unsigned COOLDOWN = 8
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  vsync_in,
    input  logic                  fire,
    input  logic [11:0]           xpos_in,
    input  logic [SLOTS-1:0]      hit_in,
    output logic [SLOTS-1:0]      on_out,
    output logic [12*SLOTS-1:0]   xpos_out,
    output logic [12*SLOTS-1:0]   ypos_out,
    output logic                  full_out,
    output logic [7:0]            shots_out
);

    localparam int unsigned POS_W = 12;
    localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [POS_W-1:0] RETIRE_LIM = POS_W'(Y_MIN + SPEED);
    localparam logic [POS_W-1:0] SPEED_V    = POS_W'(SPEED);
    localparam logic [POS_W-1:0] Y_START_V  = POS_W'(Y_START);
    localparam logic [POS_W-1:0] X_OFF_V    = POS_W'(X_OFFSET);
    localparam logic [CD_W-1:0]  COOL_V     = CD_W'(COOLDOWN);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(SLOTS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_ALLOC = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [CD_W-1:0]        cd_q, cd_d;
    logic                   pending_q, pending_d;
    logic [7:0]             shots_q, shots_d;
    logic [SLOTS-1:0]       on_q, on_d;
    logic [POS_W-1:0]       xpos_q [SLOTS];
    logic [POS_W-1:0]       xpos_d [SLOTS];
    logic [POS_W-1:0]       ypos_q [SLOTS];
    logic [POS_W-1:0]       ypos_d [SLOTS];
    logic                   vsync_d_q;
    logic                   fire_d_q;
    logic                   tick_q;

    logic [IDX_W-1:0]       sel_c;
    logic                   found_c;
    logic                   fire_edge_c;

    assign fire_edge_c = fire & ~fire_d_q;

    // First free slot at or after the round-robin pointer, wrapping.
    always_comb begin
        sel_c   = '0;
        found_c = 1'b0;
        for (int k = 0; k < int'(SLOTS); k++) begin
            if (!found_c && !on_q[IDX_W'((int'(ptr_q) + k) % int'(SLOTS))]) begin
                found_c = 1'b1;
                sel_c   = IDX_W'((int'(ptr_q) + k) % int'(SLOTS));
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cd_d      = cd_q;
        pending_d = pending_q;
        shots_d   = shots_q;
        on_d      = on_q;
        xpos_d    = xpos_q;
        ypos_d    = ypos_q;

        case (state_q)
            S_IDLE: begin
                if (tick_q) begin
                    idx_d   = '0;
                    state_d = S_MOVE;
                    if (cd_q != '0) begin
                        cd_d = cd_q - 1'b1;
                    end
                end
            end
            S_MOVE: begin
                if (on_q[idx_q]) begin
                    if (ypos_q[idx_q] < RETIRE_LIM) begin
                        on_d[idx_q] = 1'b0;
                    end else begin
                        ypos_d[idx_q] = ypos_q[idx_q] - SPEED_V;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_ALLOC;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_ALLOC: begin
                state_d   = S_IDLE;
                pending_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // A hit kills an active slot and cancels its pending move this cycle.
        for (int i = 0; i < int'(SLOTS); i++) begin
            if (hit_in[i] && on_q[i]) begin
                on_d[i]   = 1'b0;
                ypos_d[i] = ypos_q[i];
            end
        end

        // Allocation targets a free slot, so it always wins over a same-cycle hit.
        if (state_q == S_ALLOC && pending_q && cd_q == '0 && found_c) begin
            on_d[sel_c]   = 1'b1;
            xpos_d[sel_c] = xpos_in + X_OFF_V;
            ypos_d[sel_c] = Y_START_V;
            ptr_d         = (sel_c == LAST_IDX) ? '0 : sel_c + 1'b1;
            cd_d          = COOL_V;
            if (shots_q != 8'hFF) begin
                shots_d = shots_q + 8'd1;
            end
        end

        if (fire_edge_c) begin
            pending_d = 1'b1;
        end
`ifdef AUTOFIRE_EN
        if (state_q == S_IDLE && tick_q && fire) begin
            pending_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            cd_q      <= '0;
            pending_q <= 1'b0;
            shots_q   <= '0;
            on_q      <= '0;
            vsync_d_q <= 1'b0;
            fire_d_q  <= 1'b0;
            tick_q    <= 1'b0;
            for (int i = 0; i < int'(SLOTS); i++) begin
                xpos_q[i] <= '0;
                ypos_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cd_q      <= cd_d;
            pending_q <= pending_d;
            shots_q   <= shots_d;
            on_q      <= on_d;
            vsync_d_q <= vsync_in;
            fire_d_q  <= fire;
            tick_q    <= vsync_in & ~vsync_d_q;
            xpos_q    <= xpos_d;
            ypos_q    <= ypos_d;
        end
    end

    // Pack slot registers onto the flat output buses.
    always_comb begin
        xpos_out = '0;
        ypos_out = '0;
        for (int i = 0; i < int'(SLOTS); i++) begin
            xpos_out[12*i +: 12] = xpos_q[i];
            ypos_out[12*i +: 12] = ypos_q[i];
        end
    end

    assign on_out    = on_q;
    assign shots_out = shots_q;
    assign full_out  = &on_q;

endmodule

// File: tb/tb_missile_pool_ctl.sv
// Self-checking bench for missile_pool_ctl: directed scenarios plus randomized frames against a frame-level model.
module tb_missile_pool_ctl;

    localparam int SLOTS    = 4;
    localparam int Y_START  = 680;
    localparam int Y_MIN    = 0;
    localparam int SPEED    = 4;
    localparam int X_OFFSET = 30;
    localparam int COOLDOWN = 8;
`ifdef AUTOFIRE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic                  pclk = 1'b0;
    logic                  rst = 1'b0;
    logic                  vsync_in = 1'b0;
    logic                  fire = 1'b0;
    logic [11:0]           xpos_in = '0;
    logic [SLOTS-1:0]      hit_in = '0;
    logic [SLOTS-1:0]      on_out;
    logic [12*SLOTS-1:0]   xpos_out;
    logic [12*SLOTS-1:0]   ypos_out;
    logic                  full_out;
    logic [7:0]            shots_out;

    missile_pool_ctl #(
        .SLOTS(SLOTS), .Y_START(Y_START), .Y_MIN(Y_MIN),
        .SPEED(SPEED), .X_OFFSET(X_OFFSET), .COOLDOWN(COOLDOWN)
    ) dut (
        .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .fire(fire),
        .xpos_in(xpos_in), .hit_in(hit_in), .on_out(on_out),
        .xpos_out(xpos_out), .ypos_out(ypos_out),
        .full_out(full_out), .shots_out(shots_out)
    );

    always #5 pclk = ~pclk;

    int tests = 0;
    int fails = 0;

    // Frame-level reference state
    bit m_on [SLOTS];
    int m_x  [SLOTS];
    int m_y  [SLOTS];
    int m_ptr, m_cd, m_shots;
    bit m_pend;

    function automatic void m_reset();
        for (int i = 0; i < SLOTS; i++) begin
            m_on[i] = 1'b0; m_x[i] = 0; m_y[i] = 0;
        end
        m_ptr = 0; m_cd = 0; m_shots = 0; m_pend = 1'b0;
    endfunction

    function automatic void m_hit(input logic [SLOTS-1:0] h);
        for (int i = 0; i < SLOTS; i++) if (h[i]) m_on[i] = 1'b0;
    endfunction

    // One whole frame: cooldown tick, hits, movement, then the allocation decision.
    function automatic void m_frame(input logic [SLOTS-1:0] hm, input logic [SLOTS-1:0] ha,
                                    input bit held, input bit fire_in_alloc, input int x);
        int sel;
        if (AUTO && held) m_pend = 1'b1;
        if (m_cd > 0) m_cd--;
        m_hit(hm);
        for (int i = 0; i < SLOTS; i++) begin
            if (m_on[i]) begin
                if (m_y[i] < Y_MIN + SPEED) m_on[i] = 1'b0;
                else m_y[i] -= SPEED;
            end
        end
        sel = -1;
        if (m_pend && m_cd == 0) begin
            for (int k = 0; k < SLOTS; k++) begin
                if (sel < 0 && !m_on[(m_ptr + k) % SLOTS]) sel = (m_ptr + k) % SLOTS;
            end
        end
        m_hit(ha);
        if (sel >= 0) begin
            m_on[sel] = 1'b1;
            m_x[sel]  = (x + X_OFFSET) % 4096;
            m_y[sel]  = Y_START;
            m_ptr     = (sel + 1) % SLOTS;
            m_cd      = COOLDOWN;
            if (m_shots < 255) m_shots++;
        end
        m_pend = fire_in_alloc;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [SLOTS-1:0]    eo;
        logic [12*SLOTS-1:0] ex, ey;
        eo = '0; ex = '0; ey = '0;
        for (int i = 0; i < SLOTS; i++) begin
            eo[i] = m_on[i];
            ex[12*i +: 12] = 12'(m_x[i]);
            ey[12*i +: 12] = 12'(m_y[i]);
        end
        chk({tag, ".on"},    64'(on_out),    64'(eo));
        chk({tag, ".xpos"},  64'(xpos_out),  64'(ex));
        chk({tag, ".ypos"},  64'(ypos_out),  64'(ey));
        chk({tag, ".full"},  64'(full_out),  64'(&eo));
        chk({tag, ".shots"}, 64'(shots_out), 64'(m_shots));
    endtask

    task automatic do_reset();
        @(negedge pclk);
        vsync_in = 1'b0; fire = 1'b0; hit_in = '0;
        rst = 1'b0;
        m_reset();
        @(negedge pclk);
        rst = 1'b1;
        @(negedge pclk);
    endtask

    task automatic fire_pulse();
        @(negedge pclk) fire = 1'b1;
        @(negedge pclk) fire = 1'b0;
        m_pend = 1'b1;
    endtask

    task automatic quiet_hit(input logic [SLOTS-1:0] h);
        @(negedge pclk) hit_in = h;
        @(negedge pclk) hit_in = '0;
        m_hit(h);
    endtask

    // E0 samples vsync high; MOVE idx0 runs between E1 and E2; ALLOC commits at E(SLOTS+2).
    task automatic run_frame(input string tag, input logic [SLOTS-1:0] hm,
                             input logic [SLOTS-1:0] ha, input bit fea);
        bit held;
        held = fire;
        @(negedge pclk) vsync_in = 1'b1;
        @(posedge pclk);
        @(posedge pclk);
        @(negedge pclk) hit_in = hm;
        @(posedge pclk);
        @(negedge pclk) hit_in = '0;
        repeat (SLOTS - 1) @(posedge pclk);
        @(negedge pclk) begin
            hit_in = ha;
            if (fea) fire = 1'b1;
        end
        @(posedge pclk);
        @(negedge pclk) begin
            hit_in = '0;
            if (fea) fire = 1'b0;
            vsync_in = 1'b0;
        end
        m_frame(hm, ha, held, fea, int'(xpos_in));
        check_all(tag);
        repeat (2) @(negedge pclk);
    endtask

    initial begin
        m_reset();
        #23;
        chk("reset.on", 64'(on_out), 64'(0));
        chk("reset.xpos", 64'(xpos_out), 64'(0));
        chk("reset.shots", 64'(shots_out), 64'(0));
        chk("reset.full", 64'(full_out), 64'(0));
        do_reset();

        // First shot: exact latency and launch values
        xpos_in = 12'd100;
        fire_pulse();
        check_all("pre_tick");
        @(negedge pclk) vsync_in = 1'b1;
        @(posedge pclk);
        repeat (SLOTS + 1) @(posedge pclk);
        #1 chk("lat.early_on", 64'(on_out), 64'(0));
        @(posedge pclk);
        #1 begin
            chk("lat.on", 64'(on_out), 64'(1));
            chk("lat.x0", 64'(xpos_out[11:0]), 64'(130));
            chk("lat.y0", 64'(ypos_out[11:0]), 64'(680));
            chk("lat.shots", 64'(shots_out), 64'(1));
        end
        @(negedge pclk) vsync_in = 1'b0;
        m_frame('0, '0, 1'b0, 1'b0, 100);
        check_all("frame1");
        repeat (2) @(negedge pclk);
        run_frame("frame2", '0, '0, 1'b0);
        chk("move.y676", 64'(ypos_out[11:0]), 64'(676));
        run_frame("frame3", '0, '0, 1'b0);
        chk("move.y672", 64'(ypos_out[11:0]), 64'(672));

        // Request inside the cooldown window is dropped
        fire_pulse();
        run_frame("cooldown", '0, '0, 1'b0);
        chk("cooldown.shots", 64'(shots_out), 64'(1));

        // Hit during slot0's MOVE cycle, then a hit on an inactive slot
        run_frame("hit_move", 4'b0001, '0, 1'b0);
        chk("hit_move.on0", 64'(on_out[0]), 64'(0));
        chk("hit_move.y0", 64'(ypos_out[11:0]), 64'(668));
        quiet_hit(4'b0010);
        check_all("hit_idle");

        // Randomized frames
        for (int f = 0; f < 220; f++) begin
            logic [SLOTS-1:0] hm, ha;
            bit fea;
            xpos_in = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 2) == 0) fire_pulse();
            if ($urandom_range(0, 9) == 0) quiet_hit(SLOTS'($urandom));
            hm  = ($urandom_range(0, 9) == 0) ? SLOTS'($urandom) : '0;
            ha  = ($urandom_range(0, 9) == 0) ? SLOTS'($urandom) : '0;
            fea = ($urandom_range(0, 7) == 0);
            run_frame("rand", hm, ha, fea);
        end

        // Five requests 9 frames apart fill the pool and drop the fifth
        do_reset();
        for (int n = 0; n < 5; n++) begin
            xpos_in = 12'(40 * n);
            fire_pulse();
            for (int f = 0; f < 9; f++) run_frame("fill", '0, '0, 1'b0);
        end
        chk("fill.on", 64'(on_out), 64'(4'hF));
        chk("fill.full", 64'(full_out), 64'(1));
        chk("fill.shots", 64'(shots_out), 64'(4));

        // Asynchronous reset in the middle of MOVE
        do_reset();
        for (int n = 0; n < 3; n++) begin
            fire_pulse();
            for (int f = 0; f < 9; f++) run_frame("pre_rst", '0, '0, 1'b0);
        end
        @(negedge pclk) vsync_in = 1'b1;
        repeat (3) @(posedge pclk);
        #2 rst = 1'b0;
        #1 begin
            chk("midrst.on", 64'(on_out), 64'(0));
            chk("midrst.xpos", 64'(xpos_out), 64'(0));
            chk("midrst.ypos", 64'(ypos_out), 64'(0));
            chk("midrst.shots", 64'(shots_out), 64'(0));
        end
        vsync_in = 1'b0;
        m_reset();
        @(negedge pclk) rst = 1'b1;
        xpos_in = 12'd200;
        fire_pulse();
        run_frame("post_rst", '0, '0, 1'b0);
        chk("post_rst.on", 64'(on_out), 64'(1));

        // Fire held for 20 frames
        do_reset();
        xpos_in = 12'd50;
        @(negedge pclk) fire = 1'b1;
        m_pend = 1'b1;
        for (int f = 0; f < 20; f++) run_frame("held", '0, '0, 1'b0);
        chk("held.shots", 64'(shots_out), AUTO ? 64'(3) : 64'(1));
        @(negedge pclk) fire = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
